// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word type plus the instruction-cache constants, frame
// layout and controller states used by icache_direct.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // Default instruction-cache geometry (one word per frame).
  localparam int ICACHE_SETS = 16;
  localparam int IIDX_W      = $clog2(ICACHE_SETS);
  localparam int ITAG_W      = 30 - IIDX_W;

  // One cache frame at the default geometry.
  typedef struct packed {
    logic              valid;
    logic [ITAG_W-1:0] tag;
    word_t             data;
  } icache_frame_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

endpackage

// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-frame instruction cache between the fetch
// stage and the memory controller's instruction port. Hits return in the
// same cycle; a miss issues one word read and fills the frame when memory
// drops iwait, then the cache returns to IDLE and re-evaluates the request.
module icache_direct
  import cpu_types_pkg::*;
#(
  parameter int SETS = ICACHE_SETS
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  imemREN,
  input  word_t imemaddr,
  output logic  ihit,
  output word_t imemload,
  output logic  iREN,
  output word_t iaddr,
  input  logic  iwait,
  input  word_t iload
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  // Frame layout sized from this instance's SETS; matches icache_frame_t
  // at the default geometry.
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    word_t            data;
  } frame_t;

  icache_state_t state_q, state_d;
  // Word address of the outstanding miss; byte offset is implicitly 00.
  logic [29:0]   miss_word_q, miss_word_d;

  frame_t             frames_rd [SETS];
  frame_t             rd_frame;
  logic [IDX_W-1:0]   req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic [IDX_W-1:0]   fill_idx;
  logic [TAG_W-1:0]   fill_tag;
  logic               fill_en;
  logic               hit;
  logic               unused_byte_offset;

  // Byte offset of the request plays no part in lookup or fill.
  assign unused_byte_offset = ^imemaddr[1:0];

  assign req_idx  = imemaddr[IDX_W+1:2];
  assign req_tag  = imemaddr[31:IDX_W+2];
  assign fill_idx = miss_word_q[IDX_W-1:0];
  assign fill_tag = miss_word_q[29:IDX_W];
  assign rd_frame = frames_rd[req_idx];

  // Frame storage: one flop register per set, cleared by reset, written
  // only on the committing fill cycle of a miss.
  for (genvar gi = 0; gi < SETS; gi++) begin : g_frame
    frame_t frame_q;

    // Fill this frame when the outstanding miss maps to it.
    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
        frame_q <= '0;
      end else if (fill_en && (fill_idx == IDX_W'(gi))) begin
        frame_q <= '{valid: 1'b1, tag: fill_tag, data: iload};
      end
    end

    assign frames_rd[gi] = frame_q;
  end

  // Controller state and the latched miss address.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      miss_word_q <= '0;
    end else begin
      state_q     <= state_d;
      miss_word_q <= miss_word_d;
    end
  end

  // Lookup, miss detection, memory request and fill control.
  always_comb begin
    state_d     = state_q;
    miss_word_d = miss_word_q;
    ihit        = 1'b0;
    imemload    = '0;
    iREN        = 1'b0;
    iaddr       = '0;
    fill_en     = 1'b0;
    hit         = imemREN && rd_frame.valid && (rd_frame.tag == req_tag);

    case (state_q)
      IDLE: begin
        ihit = hit;
        // Data is presented for any request; ihit qualifies it.
        if (imemREN) begin
          imemload = rd_frame.data;
        end
        if (imemREN && !hit) begin
          miss_word_d = imemaddr[31:2];
          state_d     = FETCH;
        end
      end
      FETCH: begin
        // The fill is committed to the latched address even if the
        // fetch stage moves on; IDLE re-checks the live request after.
        iREN  = 1'b1;
        iaddr = {miss_word_q, 2'b00};
        if (!iwait) begin
          fill_en = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_icache_direct.sv
// Directed testbench for icache_direct: cold miss, hits, conflict,
// address change during fill, idle, and reset during a fetch.
module tb_icache_direct;
  import cpu_types_pkg::*;

  logic  CLK = 1'b0;
  logic  nRST;
  logic  imemREN;
  word_t imemaddr;
  logic  ihit;
  word_t imemload;
  logic  iREN;
  word_t iaddr;
  logic  iwait;
  word_t iload;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 CLK = ~CLK;

  icache_direct #(.SETS(16)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .ihit     (ihit),
    .imemload (imemload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload)
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    nRST     = 1'b0;
    imemREN  = 1'b1;
    imemaddr = 32'h0;
    iwait    = 1'b0;
    iload    = 32'h0;
    #3;
    vec_cnt++;
    if ({ihit, iREN, iaddr, imemload} !== {1'b0, 1'b0, 32'h0, 32'h0}) begin
      err_cnt++;
      $display("FAIL reset_outputs: got ihit=%0b iREN=%0b iaddr=%h imemload=%h want 0 0 00000000 00000000",
               ihit, iREN, iaddr, imemload);
    end
    next_cycle();
    next_cycle();
    imemREN = 1'b0;
    nRST    = 1'b1;
    #4;
    vec_cnt++;
    if ({ihit, iREN, iaddr, imemload} !== {1'b0, 1'b0, 32'h0, 32'h0}) begin
      err_cnt++;
      $display("FAIL post_reset_idle: got ihit=%0b iREN=%0b iaddr=%h imemload=%h want 0 0 00000000 00000000",
               ihit, iREN, iaddr, imemload);
    end
    next_cycle();
    $display("test_reset: done");
  endtask

  task automatic test_cold_miss();
    imemREN  = 1'b1;
    imemaddr = 32'h0;
    iwait    = 1'b1;
    iload    = 32'h2001_0005;
    #4;
    vec_cnt++;
    if ({ihit, iREN, imemload} !== {1'b0, 1'b0, 32'h0}) begin
      err_cnt++;
      $display("FAIL cold_miss_detect: got ihit=%0b iREN=%0b imemload=%h want 0 0 00000000",
               ihit, iREN, imemload);
    end
    next_cycle();
    for (int k = 0; k < 4; k++) begin
      iwait = (k < 3);
      #4;
      vec_cnt++;
      if ({ihit, iREN, iaddr} !== {1'b0, 1'b1, 32'h0}) begin
        err_cnt++;
        $display("FAIL cold_miss_fetch[%0d]: got ihit=%0b iREN=%0b iaddr=%h want 0 1 00000000",
                 k, ihit, iREN, iaddr);
      end
      next_cycle();
    end
    #4;
    vec_cnt++;
    if ({ihit, iREN, iaddr, imemload} !== {1'b1, 1'b0, 32'h0, 32'h2001_0005}) begin
      err_cnt++;
      $display("FAIL cold_miss_hit: got ihit=%0b iREN=%0b iaddr=%h imemload=%h want 1 0 00000000 20010005",
               ihit, iREN, iaddr, imemload);
    end
    next_cycle();
    $display("test_cold_miss: addr 00000000 filled");
  endtask

  task automatic test_hit_repeat();
    word_t addrs [2];
    addrs[0] = 32'h0;
    addrs[1] = 32'h2;
    iwait = 1'b0;
    iload = 32'hFFFF_FFFF;
    for (int k = 0; k < 2; k++) begin
      imemaddr = addrs[k];
      #4;
      vec_cnt++;
      if ({ihit, iREN, iaddr, imemload} !== {1'b1, 1'b0, 32'h0, 32'h2001_0005}) begin
        err_cnt++;
        $display("FAIL hit_repeat[%h]: got ihit=%0b iREN=%0b iaddr=%h imemload=%h want 1 0 00000000 20010005",
                 addrs[k], ihit, iREN, iaddr, imemload);
      end
      next_cycle();
      $display("test_hit_repeat: addr %h", addrs[k]);
    end
  endtask

  task automatic test_conflict();
    imemaddr = 32'h40;
    iwait    = 1'b0;
    iload    = 32'hDEAD_BEEF;
    #4;
    vec_cnt++;
    if ({ihit, iREN, imemload} !== {1'b0, 1'b0, 32'h2001_0005}) begin
      err_cnt++;
      $display("FAIL conflict_miss40: got ihit=%0b iREN=%0b imemload=%h want 0 0 20010005",
               ihit, iREN, imemload);
    end
    next_cycle();
    #4;
    vec_cnt++;
    if ({ihit, iREN, iaddr} !== {1'b0, 1'b1, 32'h40}) begin
      err_cnt++;
      $display("FAIL conflict_fetch40: got ihit=%0b iREN=%0b iaddr=%h want 0 1 00000040",
               ihit, iREN, iaddr);
    end
    next_cycle();
    #4;
    vec_cnt++;
    if ({ihit, iREN, imemload} !== {1'b1, 1'b0, 32'hDEAD_BEEF}) begin
      err_cnt++;
      $display("FAIL conflict_hit40: got ihit=%0b iREN=%0b imemload=%h want 1 0 deadbeef",
               ihit, iREN, imemload);
    end
    next_cycle();
    imemaddr = 32'h0;
    iload    = 32'h2001_0005;
    #4;
    vec_cnt++;
    if ({ihit, iREN, imemload} !== {1'b0, 1'b0, 32'hDEAD_BEEF}) begin
      err_cnt++;
      $display("FAIL conflict_miss0: got ihit=%0b iREN=%0b imemload=%h want 0 0 deadbeef",
               ihit, iREN, imemload);
    end
    next_cycle();
    #4;
    vec_cnt++;
    if ({ihit, iREN, iaddr} !== {1'b0, 1'b1, 32'h0}) begin
      err_cnt++;
      $display("FAIL conflict_fetch0: got ihit=%0b iREN=%0b iaddr=%h want 0 1 00000000",
               ihit, iREN, iaddr);
    end
    next_cycle();
    #4;
    vec_cnt++;
    if ({ihit, iREN, imemload} !== {1'b1, 1'b0, 32'h2001_0005}) begin
      err_cnt++;
      $display("FAIL conflict_hit0: got ihit=%0b iREN=%0b imemload=%h want 1 0 20010005",
               ihit, iREN, imemload);
    end
    next_cycle();
    $display("test_conflict: 00000040 and 00000000 swapped in set 0");
  endtask

  task automatic test_addr_change();
    imemaddr = 32'h8;
    iwait    = 1'b1;
    iload    = 32'h1111_1111;
    #4;
    vec_cnt++;
    if ({ihit, iREN} !== {1'b0, 1'b0}) begin
      err_cnt++;
      $display("FAIL chg_miss8: got ihit=%0b iREN=%0b want 0 0", ihit, iREN);
    end
    next_cycle();
    imemaddr = 32'hC;
    #4;
    vec_cnt++;
    if ({ihit, iREN, iaddr} !== {1'b0, 1'b1, 32'h8}) begin
      err_cnt++;
      $display("FAIL chg_wait: got ihit=%0b iREN=%0b iaddr=%h want 0 1 00000008", ihit, iREN, iaddr);
    end
    next_cycle();
    iwait = 1'b0;
    #4;
    vec_cnt++;
    if ({ihit, iREN, iaddr} !== {1'b0, 1'b1, 32'h8}) begin
      err_cnt++;
      $display("FAIL chg_fill8: got ihit=%0b iREN=%0b iaddr=%h want 0 1 00000008", ihit, iREN, iaddr);
    end
    next_cycle();
    iload = 32'h2222_2222;
    #4;
    vec_cnt++;
    if ({ihit, iREN, imemload} !== {1'b0, 1'b0, 32'h0}) begin
      err_cnt++;
      $display("FAIL chg_missC: got ihit=%0b iREN=%0b imemload=%h want 0 0 00000000", ihit, iREN, imemload);
    end
    next_cycle();
    #4;
    vec_cnt++;
    if ({ihit, iREN, iaddr} !== {1'b0, 1'b1, 32'hC}) begin
      err_cnt++;
      $display("FAIL chg_fetchC: got ihit=%0b iREN=%0b iaddr=%h want 0 1 0000000c", ihit, iREN, iaddr);
    end
    next_cycle();
    #4;
    vec_cnt++;
    if ({ihit, iREN, imemload} !== {1'b1, 1'b0, 32'h2222_2222}) begin
      err_cnt++;
      $display("FAIL chg_hitC: got ihit=%0b iREN=%0b imemload=%h want 1 0 22222222", ihit, iREN, imemload);
    end
    next_cycle();
    imemaddr = 32'h8;
    #4;
    vec_cnt++;
    if ({ihit, iREN, imemload} !== {1'b1, 1'b0, 32'h1111_1111}) begin
      err_cnt++;
      $display("FAIL chg_hit8: got ihit=%0b iREN=%0b imemload=%h want 1 0 11111111", ihit, iREN, imemload);
    end
    next_cycle();
    $display("test_addr_change: 00000008 and 0000000c resident");
  endtask

  task automatic test_idle();
    imemREN = 1'b0;
    iwait   = 1'b0;
    iload   = 32'h5555_AAAA;
    for (int k = 0; k < 10; k++) begin
      imemaddr = (k * 32'h0000_1234) ^ 32'h0000_0048;
      #4;
      vec_cnt++;
      if ({ihit, iREN, iaddr, imemload} !== {1'b0, 1'b0, 32'h0, 32'h0}) begin
        err_cnt++;
        $display("FAIL idle[%0d]: got ihit=%0b iREN=%0b iaddr=%h imemload=%h want 0 0 00000000 00000000",
                 k, ihit, iREN, iaddr, imemload);
      end
      next_cycle();
    end
    imemREN  = 1'b1;
    imemaddr = 32'h0;
    #4;
    vec_cnt++;
    if ({ihit, iREN, imemload} !== {1'b1, 1'b0, 32'h2001_0005}) begin
      err_cnt++;
      $display("FAIL idle_keep0: got ihit=%0b iREN=%0b imemload=%h want 1 0 20010005", ihit, iREN, imemload);
    end
    next_cycle();
    imemaddr = 32'hC;
    #4;
    vec_cnt++;
    if ({ihit, iREN, imemload} !== {1'b1, 1'b0, 32'h2222_2222}) begin
      err_cnt++;
      $display("FAIL idle_keepC: got ihit=%0b iREN=%0b imemload=%h want 1 0 22222222", ihit, iREN, imemload);
    end
    next_cycle();
    $display("test_idle: 10 idle cycles, frames intact");
  endtask

  task automatic test_reset_mid_fetch();
    imemREN  = 1'b1;
    imemaddr = 32'h10;
    iwait    = 1'b1;
    iload    = 32'h3333_3333;
    next_cycle();
    #4;
    vec_cnt++;
    if ({iREN, iaddr} !== {1'b1, 32'h10}) begin
      err_cnt++;
      $display("FAIL rst_fetch_pre: got iREN=%0b iaddr=%h want 1 00000010", iREN, iaddr);
    end
    #1;
    nRST = 1'b0;
    #1;
    vec_cnt++;
    if ({ihit, iREN, iaddr} !== {1'b0, 1'b0, 32'h0}) begin
      err_cnt++;
      $display("FAIL rst_async: got ihit=%0b iREN=%0b iaddr=%h want 0 0 00000000", ihit, iREN, iaddr);
    end
    next_cycle();
    nRST     = 1'b1;
    iwait    = 1'b0;
    imemaddr = 32'h0;
    iload    = 32'h2001_0005;
    #4;
    vec_cnt++;
    if ({ihit, iREN, imemload} !== {1'b0, 1'b0, 32'h0}) begin
      err_cnt++;
      $display("FAIL rst_miss0: got ihit=%0b iREN=%0b imemload=%h want 0 0 00000000", ihit, iREN, imemload);
    end
    next_cycle();
    #4;
    vec_cnt++;
    if ({ihit, iREN, iaddr} !== {1'b0, 1'b1, 32'h0}) begin
      err_cnt++;
      $display("FAIL rst_fetch0: got ihit=%0b iREN=%0b iaddr=%h want 0 1 00000000", ihit, iREN, iaddr);
    end
    next_cycle();
    imemaddr = 32'h10;
    iload    = 32'h4444_4444;
    #4;
    vec_cnt++;
    if ({ihit, iREN} !== {1'b0, 1'b0}) begin
      err_cnt++;
      $display("FAIL rst_discard10: got ihit=%0b iREN=%0b want 0 0", ihit, iREN);
    end
    next_cycle();
    imemREN = 1'b0;
    next_cycle();
    $display("test_reset_mid_fetch: fill discarded, frames invalid");
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_cold_miss();
    test_hit_repeat();
    test_conflict();
    test_addr_change();
    test_idle();
    test_reset_mid_fetch();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Instruction-side responder for the pipeline fetch stage.
- Services the word requests issued by the program counter (imemREN/imemaddr) and returns ihit/imemload.
- Direct-mapped, one word per frame. On a miss it issues a single-word read to the memory controller and fills the frame.
- Sits between the fetch stage and the memory controller's instruction port.

Parameters:
- SETS, 16, number of frames; power of two, at least 2.
- IDX_W, $clog2(SETS), index width; derived, not overridable.
- TAG_W, 30-IDX_W, tag width; derived, not overridable.

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- nRST  in  1  asynchronous, active-low reset.
- imemREN  in  1  fetch stage requests an instruction.
- imemaddr  in  32  byte address of the request; bits [1:0] are ignored.
- ihit  out  1  imemload is valid this cycle for imemaddr.
- imemload  out  32  instruction word.
- iREN  out  1  read request to the memory controller.
- iaddr  out  32  word-aligned memory read address.
- iwait  in  1  memory busy; iload is valid in a cycle where iREN=1 and iwait=0.
- iload  in  32  memory read data.

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-low (nRST), applied on the negedge of nRST.
- Address split:
  - [1:0] byte offset, ignored.
  - [IDX_W+1:2] index.
  - [31:IDX_W+2] tag.
- Frame contents: valid bit, TAG_W tag, 32-bit data.
- Reset state:
  - All valid bits, tags and data cleared to 0.
  - FSM in IDLE.
  - Outputs: ihit=0, iREN=0, iaddr=0, imemload=0.
- FSM states: IDLE, FETCH.
- IDLE:
  - hit = imemREN & valid[idx] & (tag[idx]==req tag).
  - ihit=hit, combinational in the same cycle (zero-cycle hit latency).
  - imemload = data[idx] whenever imemREN=1, regardless of hit; 0 when imemREN=0.
  - iREN=0, iaddr=0.
  - imemREN & !hit -> latch {imemaddr[31:2],2'b00} into miss_addr; go to FETCH.
  - imemREN=0 -> stay in IDLE; no state change.
- FETCH:
  - iREN=1, iaddr=miss_addr, ihit=0.
  - iwait=1 -> hold all outputs.
  - iwait=0 -> on the clock edge write frame[miss_addr idx] = {1, miss_addr tag, iload}; go to IDLE.
  - The following cycle is a hit if imemaddr is unchanged.
- Miss latency: N iwait cycles + 1 fill cycle + hit cycle. ihit first asserts N+2 cycles after the miss cycle.
- Fill commitment:
  - The fill always completes to miss_addr, even if imemaddr or imemREN changes during FETCH.
  - IDLE then re-evaluates the current request.
- Conflict miss: the new tag unconditionally replaces the old frame. There is no write-back because the instruction side is read-only.
- No request and fill in the same cycle: an IDLE hit never coincides with iREN=1.
- Reset mid-FETCH: iREN drops to 0 asynchronously, the fill is discarded and all frames are invalid.
- Unaligned addresses: 0x6 is treated as 0x4; iaddr is always word-aligned.

Decomposition:
- Shared package cpu_types_pkg gains:
  - IIDX_W and ITAG_W constants.
  - typedef icache_frame_t: packed {valid, tag, data}.
  - enum icache_state_t: {IDLE, FETCH}.
- Reuse word_t from the package for all 32-bit signals.
- Single module; no sub-module is needed. Frame storage is a flop array of icache_frame_t, not an SRAM macro.

Test Plan:
- Cold miss at 0x00000000, iwait=1 for 3 cycles then 0, iload=0x20010005 -> iREN=1 and iaddr=0x0 for 4 cycles, ihit=0 throughout; next IDLE cycle ihit=1, imemload=0x20010005.
- Repeat fetch of 0x0, and of 0x2 (unaligned) -> ihit=1 in the same cycle, iREN=0, imemload=0x20010005, no memory traffic.
- Conflict (SETS=16): fill 0x0, then fetch 0x40 (index 0, different tag), iload=0xDEADBEEF -> miss and fill; 0x40 then hits; refetch 0x0 misses again with iaddr=0x0.
- imemaddr changes from 0x8 to 0xC during FETCH -> fill completes to 0x8 (iaddr stays 0x8); next cycle 0xC misses and iaddr=0xC; afterwards both 0x8 and 0xC hit.
- nRST pulsed low during FETCH with iwait=1 -> iREN=0 and ihit=0 immediately; after release a fetch of the previously cached 0x0 misses.
- imemREN=0 with any imemaddr for 10 cycles -> ihit=0, iREN=0, imemload=0, no frame changes.
